// File: rtl/demux_registrado.sv
// demux_registrado: 1:2 demultiplexer with a per-channel FIFO, valid/ready handshake and delivered-word counters
module demux_registrado #(
  parameter int LARGURA = 32,
  parameter int PROF = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LARGURA-1:0] entrada,
  input  logic               controle,
  input  logic               entrada_valida,
  output logic               entrada_pronta,
  output logic [LARGURA-1:0] saidaA,
  output logic               saidaA_valida,
  input  logic               saidaA_pronta,
  output logic [LARGURA-1:0] saidaB,
  output logic               saidaB_valida,
  input  logic               saidaB_pronta,
  output logic [15:0]        contA,
  output logic [15:0]        contB
);
  logic full_a, full_b;
  // acceptance depends only on the selected channel's occupancy: no full-FIFO bypass
  always_comb entrada_pronta = controle ? !full_b : !full_a;
  demux_registrado_canal #(.LARGURA(LARGURA), .PROF(PROF)) canal_a (
    .clk(Clock), .rst(Reset), .push(entrada_valida && !controle && !full_a), .din(entrada),
    .ready(saidaA_pronta), .dout(saidaA), .valid(saidaA_valida), .full(full_a), .count(contA)
  );
  demux_registrado_canal #(.LARGURA(LARGURA), .PROF(PROF)) canal_b (
    .clk(Clock), .rst(Reset), .push(entrada_valida && controle && !full_b), .din(entrada),
    .ready(saidaB_pronta), .dout(saidaB), .valid(saidaB_valida), .full(full_b), .count(contB)
  );
endmodule

// demux_registrado_canal: one output channel - circular FIFO plus modular delivery counter
module demux_registrado_canal #(
  parameter int LARGURA = 32,
  parameter int PROF = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [LARGURA-1:0] din,
  input  logic               ready,
  output logic [LARGURA-1:0] dout,
  output logic               valid,
  output logic               full,
  output logic [15:0]        count
);
  localparam int PW = $clog2(PROF);
  localparam int OW = PW + 1;
  logic [LARGURA-1:0] mem [PROF];
  logic [PW-1:0] wr, rd;
  logic [OW-1:0] occ;
  logic pop;
  // head word is always the storage at the read pointer; pops on empty are ignored
  always_comb begin
    dout = mem[rd];
    valid = occ != '0;
    full = occ == OW'(PROF);
    pop = valid && ready;
  end
  // reset wins over push/pop; pointers wrap naturally since PROF is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PROF; i++) mem[i] <= '0;
      wr <= '0;
      rd <= '0;
      occ <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) begin
        rd <= rd + 1'b1;
        count <= count + 16'd1;
      end
      occ <= occ + OW'(push) - OW'(pop);
    end
  end
endmodule

// File: tb/tb_demux_registrado.sv
// tb_demux_registrado: randomized and directed checks of demux_registrado against a queue-based reference
module tb_demux_registrado;
  localparam int PROF = 2;
  logic Clock = 0, Reset = 0, controle = 0, entrada_valida = 0, entrada_pronta;
  logic saidaA_pronta = 0, saidaB_pronta = 0, saidaA_valida, saidaB_valida;
  logic [31:0] entrada = 0, saidaA, saidaB;
  logic [15:0] contA, contB;
  int checks = 0, errors = 0;
  logic [31:0] qa[$], qb[$];
  logic [15:0] ca = 0, cb = 0;

  demux_registrado #(.LARGURA(32), .PROF(PROF)) dut (
    .Clock(Clock), .Reset(Reset), .entrada(entrada), .controle(controle),
    .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta),
    .saidaA(saidaA), .saidaA_valida(saidaA_valida), .saidaA_pronta(saidaA_pronta),
    .saidaB(saidaB), .saidaB_valida(saidaB_valida), .saidaB_pronta(saidaB_pronta),
    .contA(contA), .contB(contB)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // apply inputs, compare outputs with the reference, then advance one clock and update the reference
  task automatic step(input logic r, input logic c, input logic v, input logic [31:0] d, input logic ra, input logic rb);
    logic acc, pa, pb;
    Reset = r; controle = c; entrada_valida = v; entrada = d; saidaA_pronta = ra; saidaB_pronta = rb;
    #1;
    acc = c ? (qb.size() < PROF) : (qa.size() < PROF);
    chk("pronta", {31'd0, entrada_pronta}, {31'd0, acc});
    chk("validA", {31'd0, saidaA_valida}, {31'd0, qa.size() != 0});
    chk("validB", {31'd0, saidaB_valida}, {31'd0, qb.size() != 0});
    if (qa.size() != 0) chk("saidaA", saidaA, qa[0]);
    if (qb.size() != 0) chk("saidaB", saidaB, qb[0]);
    chk("contA", {16'd0, contA}, {16'd0, ca});
    chk("contB", {16'd0, contB}, {16'd0, cb});
    pa = ra && qa.size() != 0;
    pb = rb && qb.size() != 0;
    @(posedge Clock);
    #1;
    if (r) begin
      qa.delete(); qb.delete(); ca = 0; cb = 0;
    end else begin
      if (pa) begin void'(qa.pop_front()); ca++; end
      if (pb) begin void'(qb.pop_front()); cb++; end
      if (v && acc) begin
        if (c) qb.push_back(d); else qa.push_back(d);
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    int na, nb;
    step(1, 0, 1, 32'h1234, 1, 1);
    chk("rst_saidaA", saidaA, 0);
    chk("rst_saidaB", saidaB, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // single word on A, then delivered
    step(0, 0, 1, 32'h80000001, 0, 0);
    chk("latA", saidaA, 32'h80000001);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("contA1", {16'd0, contA}, 1);
    // fill B, hold off a third push, drain in order
    step(0, 1, 1, 32'hAAAA0001, 0, 0);
    step(0, 1, 1, 32'hAAAA0002, 0, 0);
    chk("fullB", {31'd0, entrada_pronta}, 0);
    step(0, 1, 1, 32'hAAAA0003, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    chk("B2", saidaB, 32'hAAAA0002);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    // simultaneous push and pop on A with one word held
    step(0, 0, 1, 32'h00000011, 0, 0);
    step(0, 0, 1, 32'h00000005, 1, 0);
    chk("simA", saidaA, 32'h00000005);
    step(0, 0, 0, 0, 1, 0);
    // alternating controle, both consumers ready, 1000 words
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) step(0, i[0], 1, $urandom, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("sum1000", {16'd0, contA} + {16'd0, contB}, 1000);
    // fully random traffic with stalls
    for (int i = 0; i < 3000; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    // counter wrap on A
    step(1, 0, 0, 0, 0, 0);
    na = 0;
    while (ca != 16'hFFFF && na < 70000) begin
      step(0, 0, 1, $urandom, 1, 0);
      na++;
    end
    chk("contA_max", {16'd0, contA}, 32'h0000FFFF);
    step(0, 0, 0, 0, 1, 0);
    chk("contA_wrap", {16'd0, contA}, 0);
    // reset with both FIFOs holding words and a coincident pop
    step(0, 0, 1, 32'hC0FFEE01, 0, 0);
    step(0, 1, 1, 32'hC0FFEE02, 0, 0);
    step(1, 0, 1, 32'hC0FFEE03, 1, 1);
    chk("rstA_valid", {31'd0, saidaA_valida}, 0);
    chk("rstB_valid", {31'd0, saidaB_valida}, 0);
    chk("rst_contA", {16'd0, contA}, 0);
    chk("rst_contB", {16'd0, contB}, 0);
    nb = 0;
    for (int i = 0; i < 4; i++) step(0, i[0], 0, 0, 1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
